proj_minhash_block: RTL and testbench
=====================================

# proj_minhash_block

Downstream consumer of the FM ping-pong window buffer. Each cycle it accepts one window of KMER_LEN genome bytes (one k-mer) and 2-bit encodes it. A 3-stage hash pipeline hashes the k-mer, and the block tracks the minimum hash and its position over a fixed block of BLOCK_KMERS k-mers. It emits one (min hash, position) result per block to the sketch collector through a valid/ready output register.

## Interface
- KMER_LEN, proj_pkg::FM_ADDRESS_READ_COUNT: bytes per k-mer window.
- DATA_BITS, proj_pkg::FM_GENOME_BTYE: bits per genome byte (ASCII, 8).
- HASH_BITS, 32: hash width; must be ≤ 2*KMER_LEN rounded up to a multiple of HASH_BITS.
- BLOCK_KMERS, 1024: k-mers per block, power of two, ≥ 2.
- SEED, 32'h9E3779B9: hash seed, XORed before the multiply.

Ports:
- in_clk  in  1  clock.
- in_rst  in  1  reset, asynchronous, active-high.
- in_kmer  in  KMER_LEN*DATA_BITS  byte i at bits [(i+1)*DATA_BITS-1 : i*DATA_BITS].
- in_valid  in  1  in_kmer valid this cycle. There is no backpressure on the input.
- in_ready  in  1  downstream accepts the output result.
- out_valid  out  1  result held in the output register.
- out_min_hash  out  HASH_BITS  minimum hash of the block.
- out_min_pos  out  $clog2(BLOCK_KMERS)  k-mer index of the minimum within the block.
- out_empty  out  1  block contained no valid k-mer; hash is all-ones and pos is 0.
- out_overflow  out  1  sticky flag: a block result was dropped.

## Operation
- Encode, combinational ahead of stage 1:
  - A/a → 0, C/c → 1, G/g → 2, T/t → 3.
  - Any other byte (N, etc.) marks the k-mer as bad.
  - Byte i maps to packed bits [2i+1:2i].
- Stage 1 (fold): XOR the HASH_BITS-wide chunks of the packed value. A short final chunk is zero-extended. Also registers valid and bad.
- Stage 2 (mix): h1 = (fold ^ SEED) * proj_pkg::MH_HASH_MULT, truncated mod 2^HASH_BITS.
- Stage 3 (avalanche): h2 = h1 ^ (h1 >> HASH_BITS/2).
- Tracker, on each stage-3 valid:
  - pos counts 0..BLOCK_KMERS-1 and advances for bad k-mers as well.
  - cur_min updates when the k-mer is not bad and h2 < cur_min. The comparison is strict, so the earliest position wins a tie.
- Block end: when a valid k-mer arrives with pos = BLOCK_KMERS-1, the final min (including that k-mer) is committed to the output register.
  - pos wraps to 0, cur_min resets to all-ones, and the "seen any" flag clears.
- Output FSM, states IDLE and HOLD:
  - IDLE → HOLD on commit.
  - HOLD → IDLE when out_valid and in_ready are both high.
  - Commit in the same cycle as a HOLD-state handshake: the new result is loaded and the FSM stays in HOLD.
  - Commit in HOLD without a handshake: the new result is dropped, the old result is kept, and out_overflow is set until reset.
- in_valid gaps are bubbles: no state changes except pipeline draining.

## Timing
- Reset values:
  - out_valid = 0, out_min_hash = 0, out_min_pos = 0, out_empty = 0, out_overflow = 0.
  - cur_min = all-ones, pos = 0, all stage valids = 0, FSM in IDLE.
- Reset while a block is partial discards the block; the pipeline contents are lost.
- Latency: a k-mer sampled at edge t occupies stage 1/2/3 at edges t+1/t+2/t+3. Its commit to the output register is at edge t+4, so out_valid is high after edge t+4.
- Throughput: one k-mer per cycle sustained, with no stalls.
- Output handshake:
  - out_* is stable while out_valid=1 && in_ready=0.
  - A transfer occurs on an edge where out_valid=1 && in_ready=1.
  - in_ready is ignored while out_valid=0.

## Structure
- proj_pkg additions:
  - MH_HASH_MULT (32'h85EBCA6B).
  - typedef mh_hash_t (logic [HASH_BITS-1:0]).
  - ASCII nucleotide constants.
  - Function mh_encode_base returning {bad, code[1:0]}.
- Sub-module proj_kmer_hash_pipe contains the encode, fold, mix and avalanche logic (3 registered stages, valid/bad sideband). proj_minhash_block instantiates it and adds the tracker and output FSM.

## Test plan
- BLOCK_KMERS=4 case: four distinct valid k-mers, contiguous in_valid, in_ready=1.
  - out_valid pulses for 1 cycle, 4 cycles after the 4th input edge.
  - out_min_hash and out_min_pos match the software model; out_empty=0.
- Tie: k-mers 1 and 3 are identical and are the minimum → out_min_pos=1.
- Bad k-mers: a block where every k-mer contains 'N' → out_empty=1, out_min_hash=32'hFFFFFFFF, out_min_pos=0.
- Mixed bad k-mers: a block where only k-mer 2 contains 'N' → the minimum is taken over k-mers 0, 1 and 3, and position numbering is unaffected.
- Backpressure: hold in_ready=0 across two block commits.
  - The first result stays stable and out_overflow=1.
  - After in_ready=1, the first result transfers and out_valid drops.
- Same-cycle commit: in_ready is asserted on the same edge as the next commit → no overflow, and the second result appears the following cycle.
- Async reset: assert in_rst mid-block for 1 cycle, with no clock edge needed for outputs to clear.
  - All outputs are 0 immediately.
  - A fresh full block then yields a result identical to the same block sent without the reset.
- Bubbles: in_valid toggling 1/0 produces the same result as contiguous input, delayed accordingly.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared constants, hash multiplier and nucleotide encoding for the FM / minhash path.
package proj_pkg;
  localparam int FM_ADDRESS_READ_COUNT = 20;
  localparam int FM_GENOME_BTYE        = 8;
  localparam int MH_HASH_BITS          = 32;
  localparam logic [31:0] MH_HASH_MULT = 32'h85EBCA6B;

  typedef logic [MH_HASH_BITS-1:0] mh_hash_t;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_G = 8'h47;
  localparam logic [7:0] ASCII_T = 8'h54;
  localparam logic [7:0] ASCII_LC = 8'h20;

  // {bad, code[1:0]}; lowercase differs from uppercase only in bit 5
  function automatic logic [2:0] mh_encode_base(input logic [7:0] b);
    case (b)
      ASCII_A, ASCII_A | ASCII_LC: return 3'b0_00;
      ASCII_C, ASCII_C | ASCII_LC: return 3'b0_01;
      ASCII_G, ASCII_G | ASCII_LC: return 3'b0_10;
      ASCII_T, ASCII_T | ASCII_LC: return 3'b0_11;
      default:                     return 3'b1_00;
    endcase
  endfunction
endpackage

// File: rtl/proj_minhash_if.sv
// k-mer input and (min hash, position) result bus of the minhash block.
interface proj_minhash_if #(
  parameter int KMER_LEN  = 20,
  parameter int DATA_BITS = 8,
  parameter int HASH_BITS = 32,
  parameter int POS_W     = 10
);
  logic [KMER_LEN*DATA_BITS-1:0] in_kmer;
  logic                          in_valid;
  logic                          in_ready;
  logic                          out_valid;
  logic [HASH_BITS-1:0]          out_min_hash;
  logic [POS_W-1:0]              out_min_pos;
  logic                          out_empty;
  logic                          out_overflow;

  modport master (
    output in_kmer, in_valid, in_ready,
    input  out_valid, out_min_hash, out_min_pos, out_empty, out_overflow
  );
  modport slave (
    input  in_kmer, in_valid, in_ready,
    output out_valid, out_min_hash, out_min_pos, out_empty, out_overflow
  );
endinterface

// File: rtl/proj_minhash_block_hash_pipe.sv
// Input register, then encode+fold / mix / avalanche as three registered stages with valid/bad sideband.
module proj_kmer_hash_pipe
  import proj_pkg::*;
#(
  parameter int KMER_LEN  = FM_ADDRESS_READ_COUNT,
  parameter int DATA_BITS = FM_GENOME_BTYE,
  parameter int HASH_BITS = 32,
  parameter logic [HASH_BITS-1:0] SEED = 32'h9E3779B9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KMER_LEN*DATA_BITS-1:0] kmer_i,
  input  logic                          valid_i,
  output logic                          valid_o,
  output logic                          bad_o,
  output logic [HASH_BITS-1:0]          hash_o
);
  localparam int STAGES = 3;
  localparam int PACK_W = 2*KMER_LEN;
  localparam int NCHUNK = (PACK_W + HASH_BITS - 1) / HASH_BITS;

  logic [STAGES:0]               vld_pipe_q;
  logic [STAGES:1]               bad_pipe_q;
  logic [KMER_LEN*DATA_BITS-1:0] kmer_q;
  logic [KMER_LEN-1:0][2:0]      enc;
  logic [NCHUNK*HASH_BITS-1:0]   pack_ext;
  logic                          bad_d;
  logic [HASH_BITS-1:0]          fold_d, fold_q, h1_d, h1_q, h2_q;

  for (genvar g = 0; g < KMER_LEN; g++) begin : g_enc
    assign enc[g] = mh_encode_base(kmer_q[g*DATA_BITS +: 8]);
  end

  // short top chunk is zero-extended by the '0 default of pack_ext
  always_comb begin
    pack_ext = '0;
    bad_d    = 1'b0;
    fold_d   = '0;
    for (int i = 0; i < KMER_LEN; i++) begin
      pack_ext[2*i +: 2] = enc[i][1:0];
      bad_d              = bad_d | enc[i][2];
    end
    for (int c = 0; c < NCHUNK; c++) fold_d = fold_d ^ pack_ext[c*HASH_BITS +: HASH_BITS];
  end

  assign h1_d = (fold_q ^ SEED) * HASH_BITS'(MH_HASH_MULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      bad_pipe_q <= '0;
      kmer_q     <= '0;
      fold_q     <= '0;
      h1_q       <= '0;
      h2_q       <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], valid_i};
      bad_pipe_q <= {bad_pipe_q[STAGES-1:1], bad_d};
      kmer_q     <= kmer_i;
      fold_q     <= fold_d;
      h1_q       <= h1_d;
      h2_q       <= h1_q ^ (h1_q >> (HASH_BITS/2));
    end
  end

  assign valid_o = vld_pipe_q[STAGES];
  assign bad_o   = bad_pipe_q[STAGES];
  assign hash_o  = h2_q;
endmodule

// File: rtl/proj_minhash_block.sv
// Per-block minimum-hash tracker with a one-deep valid/ready result register.
module proj_minhash_block
  import proj_pkg::*;
#(
  parameter int KMER_LEN    = FM_ADDRESS_READ_COUNT,
  parameter int DATA_BITS   = FM_GENOME_BTYE,
  parameter int HASH_BITS   = 32,
  parameter int BLOCK_KMERS = 1024,
  parameter logic [HASH_BITS-1:0] SEED = 32'h9E3779B9
) (
  input  logic            in_clk,
  input  logic            in_rst,
  proj_minhash_if.slave   bus
);
  localparam int POS_W = $clog2(BLOCK_KMERS);
  typedef enum logic {IDLE, HOLD} ostate_e;

  logic                 s3_vld, s3_bad;
  logic [HASH_BITS-1:0] s3_hash;

  proj_kmer_hash_pipe #(
    .KMER_LEN(KMER_LEN), .DATA_BITS(DATA_BITS), .HASH_BITS(HASH_BITS), .SEED(SEED)
  ) u_pipe (
    .clk(in_clk), .rst(in_rst), .kmer_i(bus.in_kmer), .valid_i(bus.in_valid),
    .valid_o(s3_vld), .bad_o(s3_bad), .hash_o(s3_hash)
  );

  logic [POS_W-1:0]     pos_q, min_pos_q, min_pos_d;
  logic [HASH_BITS-1:0] cur_min_q, min_d;
  logic                 seen_q, take, commit, empty_d;

  // strict compare keeps the earliest position on ties
  assign take      = s3_vld && !s3_bad && (s3_hash < cur_min_q);
  assign min_d     = take ? s3_hash : cur_min_q;
  assign min_pos_d = take ? pos_q : min_pos_q;
  assign empty_d   = !(seen_q || !s3_bad);
  assign commit    = s3_vld && (&pos_q);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      pos_q     <= '0;
      min_pos_q <= '0;
      cur_min_q <= '1;
      seen_q    <= 1'b0;
    end else if (s3_vld) begin
      pos_q <= pos_q + 1'b1;
      if (commit) begin
        min_pos_q <= '0;
        cur_min_q <= '1;
        seen_q    <= 1'b0;
      end else begin
        min_pos_q <= min_pos_d;
        cur_min_q <= min_d;
        seen_q    <= seen_q || !s3_bad;
      end
    end
  end

  ostate_e              state_q;
  logic                 out_valid_q, out_empty_q, out_ovf_q;
  logic [HASH_BITS-1:0] out_hash_q;
  logic [POS_W-1:0]     out_pos_q;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_hash_q  <= '0;
      out_pos_q   <= '0;
      out_empty_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (commit) begin
          state_q     <= HOLD;
          out_valid_q <= 1'b1;
          out_hash_q  <= min_d;
          out_pos_q   <= min_pos_d;
          out_empty_q <= empty_d;
        end
        HOLD: if (commit && bus.in_ready) begin
          out_hash_q  <= min_d;
          out_pos_q   <= min_pos_d;
          out_empty_q <= empty_d;
        end else if (commit) begin
          out_ovf_q <= 1'b1;
        end else if (bus.in_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_min_hash = out_hash_q;
  assign bus.out_min_pos  = out_pos_q;
  assign bus.out_empty    = out_empty_q;
  assign bus.out_overflow = out_ovf_q;
endmodule

// File: tb/tb_proj_minhash_block.sv
// Bench for proj_minhash_block with 4-k-mer blocks against an arithmetic reference model.
module tb_proj_minhash_block;
  import proj_pkg::*;

  localparam int K  = 20;
  localparam int NB = 4;
  localparam logic [31:0] SEED_P = 32'h9E3779B9;

  typedef logic [K*8-1:0] kmer_t;
  typedef struct {
    kmer_t       k [NB];
    logic [31:0] exp_hash;
    int          exp_pos;
    bit          exp_empty;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  proj_minhash_if #(.KMER_LEN(K), .DATA_BITS(8), .HASH_BITS(32), .POS_W(2)) bus ();

  proj_minhash_block #(
    .KMER_LEN(K), .DATA_BITS(8), .HASH_BITS(32), .BLOCK_KMERS(NB), .SEED(SEED_P)
  ) dut (
    .in_clk(clk), .in_rst(rst), .bus(bus)
  );

  int nerr = 0;
  int nchk = 0;
  logic [7:0] bases [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic kmer_t rand_kmer();
    kmer_t k;
    for (int i = 0; i < K; i++) k[i*8 +: 8] = bases[$urandom_range(0, 7)];
    return k;
  endfunction

  // reference: base-4 number of the k-mer, XOR of 32-bit slices, multiply, avalanche
  function automatic mh_hash_t ref_hash(input kmer_t k, output bit bad);
    logic [63:0] v, m;
    logic [31:0] f, h1;
    logic [7:0]  b;
    int code;
    v = 0; bad = 0;
    for (int i = 0; i < K; i++) begin
      b = k[i*8 +: 8];
      case (b)
        "A", "a": code = 0;
        "C", "c": code = 1;
        "G", "g": code = 2;
        "T", "t": code = 3;
        default: begin code = 0; bad = 1; end
      endcase
      v = v + (64'(code) << (2*i));
    end
    f = 0;
    while (v != 0) begin f = f ^ v[31:0]; v = v >> 32; end
    m  = 64'(f ^ SEED_P) * 64'(MH_HASH_MULT);
    h1 = m[31:0];
    return h1 ^ (h1 >> 16);
  endfunction

  function automatic void ref_block(input kmer_t k [NB], output logic [31:0] mn,
                                    output int pos, output bit empty);
    logic [31:0] h;
    bit bad;
    mn = 32'hFFFF_FFFF; pos = 0; empty = 1;
    for (int i = 0; i < NB; i++) begin
      h = ref_hash(k[i], bad);
      if (!bad) begin
        empty = 0;
        if (h < mn) begin mn = h; pos = i; end
      end
    end
  endfunction

  task automatic send_block(input kmer_t k [NB], input bit gaps);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk); bus.in_valid = 1'b1; bus.in_kmer = k[i];
      if (gaps) begin
        @(negedge clk); bus.in_valid = 1'b0; bus.in_kmer = rand_kmer();
      end
    end
    if (!gaps) begin @(negedge clk); bus.in_valid = 1'b0; end
  endtask

  // counts edges from the last input edge until out_valid rises
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 12) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic run_vec(input vec_t v, input bit gaps, input string tag);
    int cyc;
    send_block(v.k, gaps);
    wait_out(cyc);
    chk({tag, " latency"}, cyc, 4);
    chk({tag, " hash"}, bus.out_min_hash, v.exp_hash);
    chk({tag, " pos"}, bus.out_min_pos, v.exp_pos);
    chk({tag, " empty"}, bus.out_empty, v.exp_empty);
    chk({tag, " overflow"}, bus.out_overflow, 0);
    @(posedge clk); #1;
    chk({tag, " pulse"}, bus.out_valid, 0);
  endtask

  function automatic vec_t mk_vec(input kmer_t k [NB]);
    vec_t v;
    v.k = k;
    ref_block(k, v.exp_hash, v.exp_pos, v.exp_empty);
    return v;
  endfunction

  vec_t tbl [6];

  initial begin
    kmer_t ks [NB];
    vec_t  va, vb;
    int    cyc;
    bit    bd;
    logic [31:0] h1;

    bases = '{"A", "C", "G", "T", "a", "c", "g", "t"};

    // random blocks
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NB; i++) ks[i] = rand_kmer();
      tbl[t] = mk_vec(ks);
    end
    // tie: k-mers 1 and 3 identical and smallest
    ks[1] = rand_kmer();
    h1 = ref_hash(ks[1], bd);
    for (int i = 0; i < NB; i += 2) begin
      ks[i] = rand_kmer();
      for (int n = 0; n < 1000 && ref_hash(ks[i], bd) <= h1; n++) ks[i] = rand_kmer();
    end
    ks[3] = ks[1];
    tbl[3] = mk_vec(ks);
    tbl[3].exp_pos = 1;
    // every k-mer bad
    for (int i = 0; i < NB; i++) begin
      ks[i] = rand_kmer();
      ks[i][$urandom_range(0, K-1)*8 +: 8] = "N";
    end
    tbl[4].k = ks; tbl[4].exp_hash = 32'hFFFF_FFFF; tbl[4].exp_pos = 0; tbl[4].exp_empty = 1;
    // only k-mer 2 bad
    for (int i = 0; i < NB; i++) ks[i] = rand_kmer();
    ks[2][$urandom_range(0, K-1)*8 +: 8] = "N";
    tbl[5] = mk_vec(ks);

    rst = 1'b1; bus.in_valid = 1'b0; bus.in_ready = 1'b1; bus.in_kmer = '0;
    #1;
    chk("reset valid", bus.out_valid, 0);
    chk("reset hash", bus.out_min_hash, 0);
    chk("reset pos", bus.out_min_pos, 0);
    chk("reset empty", bus.out_empty, 0);
    chk("reset overflow", bus.out_overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 6; t++) run_vec(tbl[t], 1'b0, $sformatf("vec%0d", t));

    run_vec(tbl[0], 1'b1, "bubbles");

    // same-cycle handshake and commit
    for (int i = 0; i < NB; i++) ks[i] = rand_kmer();
    va = mk_vec(ks);
    for (int i = 0; i < NB; i++) ks[i] = rand_kmer();
    vb = mk_vec(ks);
    bus.in_ready = 1'b0;
    send_block(va.k, 1'b0);
    wait_out(cyc);
    chk("same A latency", cyc, 4);
    chk("same A hash", bus.out_min_hash, va.exp_hash);
    send_block(vb.k, 1'b0);
    repeat (3) @(negedge clk);
    bus.in_ready = 1'b1;
    @(posedge clk); #1;
    chk("same B valid", bus.out_valid, 1);
    chk("same B hash", bus.out_min_hash, vb.exp_hash);
    chk("same B pos", bus.out_min_pos, vb.exp_pos);
    chk("same overflow", bus.out_overflow, 0);
    @(posedge clk); #1;
    chk("same B drained", bus.out_valid, 0);

    // backpressure across two commits
    @(negedge clk); bus.in_ready = 1'b0;
    send_block(va.k, 1'b0);
    wait_out(cyc);
    chk("bp A latency", cyc, 4);
    send_block(vb.k, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("bp valid held", bus.out_valid, 1);
    chk("bp hash held", bus.out_min_hash, va.exp_hash);
    chk("bp pos held", bus.out_min_pos, va.exp_pos);
    chk("bp overflow", bus.out_overflow, 1);
    @(negedge clk); bus.in_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp transfer", bus.out_valid, 0);
    chk("bp overflow sticky", bus.out_overflow, 1);

    // async reset mid-block, between clock edges
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); bus.in_valid = 1'b1; bus.in_kmer = tbl[1].k[i];
    end
    @(negedge clk); bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst valid", bus.out_valid, 0);
    chk("arst hash", bus.out_min_hash, 0);
    chk("arst pos", bus.out_min_pos, 0);
    chk("arst empty", bus.out_empty, 0);
    chk("arst overflow", bus.out_overflow, 0);
    @(negedge clk); rst = 1'b0;
    run_vec(tbl[1], 1'b0, "post-reset");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
